// File: rtl/nlms_pkg.sv
// Shared constants and fixed-point helpers for the adaptive FIR engine.
// The helpers work on 64-bit intermediates so any sample width up to 32 fits.
package nlms_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FIR   = 3'd2;
    localparam logic [2:0] ST_ERR   = 3'd3;
    localparam logic [2:0] ST_ADAPT = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;

    localparam logic [1:0] OP_FIR = 2'd0;
    localparam logic [1:0] OP_LMS = 2'd1;

    function automatic longint sat_w(longint v, int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Division by 2^q rounding toward zero, not toward minus infinity.
    function automatic longint trunc_div(longint v, int q);
        if (v < 0) return -((-v) >>> q);
        return v >>> q;
    endfunction

    function automatic longint cond_x(longint raw, int bits, logic u2, logic fract,
                                      int q, int w);
        longint v;
        int     b;
        b = bits;
        if (b < 1) b = 1;
        if (b > w) b = w;
        v = raw & ((longint'(1) <<< b) - 1);
        if (u2) begin
            if (v[b-1]) v = v - (longint'(1) <<< b);
        end else begin
            v = v - (longint'(1) <<< (b - 1));
        end
        if (!fract) v = sat_w(v <<< q, w);
        return v;
    endfunction

endpackage

// File: rtl/nlms_filter_if.sv
// Control/status bundle between the register wrapper and the filter engine.
interface nlms_filter_if #(
    parameter int LOG2_H_BUFF_HEIGHT   = 7,
    parameter int LOG2_X_D_BUFF_HEIGHT = 7,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int LOG2_NUM_MULS        = 2
);
    // Handshake: start is a single-cycle request taken only while busy is low;
    // busy stays high until the block is done, and abort_processing wins over all.
    logic                                          en;
    logic                                          start;
    logic                                          abort_processing;
    logic [1:0]                                    operation;
    logic [LOG2_X_D_BUFF_HEIGHT:0]                 x_count;
    logic [LOG2_H_BUFF_HEIGHT-LOG2_NUM_MULS:0]     h_coefs_blocks;
    logic                                          x_samples_u2;
    logic                                          x_fract;
    logic [4:0]                                    actual_input_bits;
    logic                                          y_as_out;
    logic                                          reset_out_ptr;
    logic signed [SAMPLE_WIDTH-1:0]                mi;
    logic                                          busy;
    logic [2:0]                                    state_dbg;

    modport master (
        output en, start, abort_processing, operation, x_count, h_coefs_blocks,
               x_samples_u2, x_fract, actual_input_bits, y_as_out, reset_out_ptr, mi,
        input  busy, state_dbg
    );

    modport slave (
        input  en, start, abort_processing, operation, x_count, h_coefs_blocks,
               x_samples_u2, x_fract, actual_input_bits, y_as_out, reset_out_ptr, mi,
        output busy, state_dbg
    );

endinterface

// File: rtl/nlms_mac_lane.sv
// One multiply lane: full-width signed product, scaled by 2^-Q toward zero, saturated to W.
module nlms_mac_lane
    import nlms_pkg::*;
#(
    parameter int SAMPLE_WIDTH    = 16,
    parameter int SAMPLE_Q_FORMAT = 8
) (
    input  logic signed [SAMPLE_WIDTH-1:0] a,
    input  logic signed [SAMPLE_WIDTH-1:0] b,
    output logic signed [SAMPLE_WIDTH-1:0] term
);

    logic signed [2*SAMPLE_WIDTH-1:0] prod;
    longint                           scaled;

    assign prod = a * b;

    always_comb begin
        scaled = sat_w(trunc_div(longint'(prod), SAMPLE_Q_FORMAT), SAMPLE_WIDTH);
        term   = SAMPLE_WIDTH'(scaled);
    end

endmodule

// File: rtl/nlms_filter_top.sv
// Block-based adaptive FIR/LMS engine with register-array buffers preloaded at reset.
// M shared lanes serve the FIR pass, the error scaling and the coefficient update.
module nlms_filter_top
    import nlms_pkg::*;
#(
    parameter int LOG2_H_BUFF_HEIGHT   = 7,
    parameter int LOG2_X_D_BUFF_HEIGHT = 7,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int LOG2_NUM_MULS        = 2,
    parameter int SAMPLE_Q_FORMAT      = 8
) (
    input  logic                                                 clk,
    input  logic                                                 nrst,
    nlms_filter_if.slave                                         ctrl,
    input  logic [(2**LOG2_H_BUFF_HEIGHT)*SAMPLE_WIDTH-1:0]      h_buff_reset_val,
    input  logic [(2**LOG2_H_BUFF_HEIGHT)*SAMPLE_WIDTH-1:0]      x_fifo_buff_reset_val,
    input  logic [(2**LOG2_X_D_BUFF_HEIGHT)*SAMPLE_WIDTH-1:0]    x_buff_ping_reset_val,
    input  logic [(2**LOG2_X_D_BUFF_HEIGHT)*SAMPLE_WIDTH-1:0]    d_buff_ping_reset_val,
    input  logic [(2**LOG2_X_D_BUFF_HEIGHT)*SAMPLE_WIDTH-1:0]    out_buff_reset_val,
    output logic [(2**LOG2_H_BUFF_HEIGHT)*SAMPLE_WIDTH-1:0]      h_buff,
    output logic [(2**LOG2_X_D_BUFF_HEIGHT)*SAMPLE_WIDTH-1:0]    out_buff
);

    localparam int W     = SAMPLE_WIDTH;
    localparam int LH    = LOG2_H_BUFF_HEIGHT;
    localparam int LN    = LOG2_X_D_BUFF_HEIGHT;
    localparam int LM    = LOG2_NUM_MULS;
    localparam int H     = 2**LH;
    localparam int N     = 2**LN;
    localparam int M     = 2**LM;
    localparam int BLK_W = LH - LM + 1;
    localparam int CNT_W = LN + 1;

    logic signed [W-1:0] h_mem   [H];
    logic signed [W-1:0] hist    [H];
    logic signed [W-1:0] x_mem   [N];
    logic signed [W-1:0] d_mem   [N];
    logic signed [W-1:0] out_mem [N];

    logic [2:0]          state;
    logic [BLK_W-1:0]    blk_cnt;
    logic [CNT_W-1:0]    idx;
    logic [LN-1:0]       out_ptr;
    logic signed [W-1:0] y_acc;
    logic signed [W-1:0] adapt_step;

    logic [LN-1:0]       sample_addr;
    logic signed [W-1:0] err_c;
    longint              x_cond_l;
    logic signed [W-1:0] x_cond;
    logic                blk_valid;
    logic                last_blk;
    logic [LH-1:0]       tap_idx    [M];
    logic signed [W-1:0] lane_a     [M];
    logic signed [W-1:0] lane_b     [M];
    logic signed [W-1:0] lane_term  [M];
    logic signed [W-1:0] fir_sum;

    assign sample_addr = idx[LN-1:0];
    assign err_c       = d_mem[sample_addr] - y_acc;
    assign blk_valid   = blk_cnt < ctrl.h_coefs_blocks;
    assign last_blk    = (ctrl.h_coefs_blocks == '0) ||
                         (blk_cnt == ctrl.h_coefs_blocks - BLK_W'(1));

    always_comb begin
        x_cond_l = cond_x(longint'(x_mem[sample_addr]), int'(ctrl.actual_input_bits),
                          ctrl.x_samples_u2, ctrl.x_fract, SAMPLE_Q_FORMAT, W);
        x_cond   = W'(x_cond_l);
    end

    // Lane 0 is borrowed in ERR to scale the error by the step size.
    always_comb begin
        for (int m = 0; m < M; m++) begin
            tap_idx[m] = {blk_cnt[BLK_W-2:0], LM'(m)};
            lane_a[m]  = hist[tap_idx[m]];
            lane_b[m]  = (state == ST_ADAPT) ? adapt_step : h_mem[tap_idx[m]];
        end
        if (state == ST_ERR) begin
            lane_a[0] = err_c;
            lane_b[0] = ctrl.mi;
        end
    end

    for (genvar g = 0; g < M; g++) begin : g_lane
        nlms_mac_lane #(
            .SAMPLE_WIDTH    (W),
            .SAMPLE_Q_FORMAT (SAMPLE_Q_FORMAT)
        ) u_lane (
            .a    (lane_a[g]),
            .b    (lane_b[g]),
            .term (lane_term[g])
        );
    end

    always_comb begin
        fir_sum = y_acc;
        for (int m = 0; m < M; m++) fir_sum = fir_sum + lane_term[m];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < H; k++) begin
                h_mem[k] <= h_buff_reset_val[k*W +: W];
                hist[k]  <= x_fifo_buff_reset_val[k*W +: W];
            end
            for (int k = 0; k < N; k++) begin
                x_mem[k]   <= x_buff_ping_reset_val[k*W +: W];
                d_mem[k]   <= d_buff_ping_reset_val[k*W +: W];
                out_mem[k] <= out_buff_reset_val[k*W +: W];
            end
            state      <= ST_IDLE;
            blk_cnt    <= '0;
            idx        <= '0;
            out_ptr    <= '0;
            y_acc      <= '0;
            adapt_step <= '0;
        end else if (ctrl.en) begin
            if (ctrl.abort_processing) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ctrl.start) begin
                            state <= ST_LOAD;
                            idx   <= '0;
                            if (ctrl.reset_out_ptr) out_ptr <= '0;
                        end
                    end
                    ST_LOAD: begin
                        // Only reachable with idx >= x_count when x_count is zero.
                        if (idx >= ctrl.x_count) begin
                            state <= ST_IDLE;
                        end else begin
                            for (int k = H - 1; k > 0; k--) hist[k] <= hist[k-1];
                            hist[0] <= x_cond;
                            y_acc   <= '0;
                            blk_cnt <= '0;
                            state   <= ST_FIR;
                        end
                    end
                    ST_FIR: begin
                        if (blk_valid) y_acc <= fir_sum;
                        if (last_blk) begin
                            blk_cnt <= '0;
                            state   <= (ctrl.operation == OP_LMS) ? ST_ERR : ST_WRITE;
                        end else begin
                            blk_cnt <= blk_cnt + BLK_W'(1);
                        end
                    end
                    ST_ERR: begin
                        adapt_step <= lane_term[0];
                        state      <= ST_ADAPT;
                    end
                    ST_ADAPT: begin
                        if (blk_valid) begin
                            for (int m = 0; m < M; m++)
                                h_mem[tap_idx[m]] <= h_mem[tap_idx[m]] + lane_term[m];
                        end
                        if (last_blk) begin
                            blk_cnt <= '0;
                            state   <= ST_WRITE;
                        end else begin
                            blk_cnt <= blk_cnt + BLK_W'(1);
                        end
                    end
                    ST_WRITE: begin
                        out_mem[out_ptr] <= ctrl.y_as_out ? y_acc : err_c;
                        out_ptr          <= out_ptr + LN'(1);
                        idx              <= idx + CNT_W'(1);
                        state <= (idx + CNT_W'(1) >= ctrl.x_count) ? ST_IDLE : ST_LOAD;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ctrl.busy      = (state != ST_IDLE);
    assign ctrl.state_dbg = state;

    for (genvar g = 0; g < H; g++) begin : g_h_out
        assign h_buff[g*W +: W] = h_mem[g];
    end

    for (genvar g = 0; g < N; g++) begin : g_o_out
        assign out_buff[g*W +: W] = out_mem[g];
    end

endmodule

// File: tb/tb_nlms_filter_top.sv
// Directed and randomized checks of nlms_filter_top against a plain-arithmetic model.
module tb_nlms_filter_top;
  import nlms_pkg::*;

  localparam int LH = 7;
  localparam int LN = 7;
  localparam int W  = 16;
  localparam int LM = 2;
  localparam int Q  = 8;
  localparam int H  = 2**LH;
  localparam int N  = 2**LN;
  localparam int M  = 2**LM;

  // clock / reset
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  nlms_filter_if #(
    .LOG2_H_BUFF_HEIGHT(LH), .LOG2_X_D_BUFF_HEIGHT(LN),
    .SAMPLE_WIDTH(W), .LOG2_NUM_MULS(LM)
  ) intf ();

  logic [H*W-1:0] h_img, hist_img, h_buff;
  logic [N*W-1:0] x_img, d_img, out_img, out_buff;

  nlms_filter_top #(
    .LOG2_H_BUFF_HEIGHT(LH), .LOG2_X_D_BUFF_HEIGHT(LN),
    .SAMPLE_WIDTH(W), .LOG2_NUM_MULS(LM), .SAMPLE_Q_FORMAT(Q)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .ctrl(intf.slave),
    .h_buff_reset_val(h_img),
    .x_fifo_buff_reset_val(hist_img),
    .x_buff_ping_reset_val(x_img),
    .d_buff_ping_reset_val(d_img),
    .out_buff_reset_val(out_img),
    .h_buff(h_buff),
    .out_buff(out_buff)
  );

  // reference model state
  int mh[H];
  int mhist[H];
  int mx[N];
  int md[N];
  int mout[N];
  int mptr;
  int m_y;
  int m_err;

  int c_op, c_xc, c_blk, c_u2, c_fract, c_bits, c_yo, c_rptr, c_mi;

  int checks = 0;
  int errors = 0;

  function automatic int sat16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int wrap16(longint v);
    longint r;
    r = v % 65536;
    if (r < 0) r += 65536;
    if (r >= 32768) r -= 65536;
    return int'(r);
  endfunction

  function automatic int scale(longint a, longint b);
    return sat16((a * b) / 256);
  endfunction

  function automatic int cond_model(int raw, int bits, int u2, int fract);
    int b;
    longint span;
    longint v;
    b = (bits < 1) ? 1 : ((bits > 16) ? 16 : bits);
    span = longint'(1) << b;
    v = longint'(raw) % span;
    if (v < 0) v += span;
    if (u2 != 0) begin
      if (v >= span / 2) v -= span;
    end else begin
      v -= span / 2;
    end
    if (fract == 0) return sat16(v * 256);
    return int'(v);
  endfunction

  function automatic int out_at(int k);
    return int'($signed(out_buff[k*W +: W]));
  endfunction

  function automatic int h_at(int k);
    return int'($signed(h_buff[k*W +: W]));
  endfunction

  // scoreboard helpers
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_bufs(input string tag);
    for (int k = 0; k < N; k++) check($sformatf("%s out[%0d]", tag, k), out_at(k), mout[k]);
    for (int k = 0; k < H; k++) check($sformatf("%s h[%0d]", tag, k), h_at(k), mh[k]);
  endtask

  task automatic clear_model();
    for (int k = 0; k < H; k++) begin
      mh[k] = 0;
      mhist[k] = 0;
    end
    for (int k = 0; k < N; k++) begin
      mx[k] = 0;
      md[k] = 0;
      mout[k] = 0;
    end
  endtask

  task automatic model_front(input int i);
    for (int k = H - 1; k > 0; k--) mhist[k] = mhist[k-1];
    mhist[0] = cond_model(mx[i], c_bits, c_u2, c_fract);
    m_y = 0;
    for (int j = 0; j < c_blk * M; j++) m_y = wrap16(m_y + scale(mhist[j], mh[j]));
    m_err = wrap16(md[i] - m_y);
  endtask

  task automatic model_adapt(input int ntaps);
    int a;
    a = scale(m_err, c_mi);
    for (int j = 0; j < ntaps; j++) mh[j] = wrap16(mh[j] + scale(mhist[j], a));
  endtask

  task automatic model_run();
    if (c_rptr != 0) mptr = 0;
    for (int i = 0; i < c_xc; i++) begin
      model_front(i);
      if (c_op == 1) model_adapt(c_blk * M);
      mout[mptr] = (c_yo != 0) ? m_y : m_err;
      mptr = (mptr + 1) % N;
    end
  endtask

  // driver tasks
  task automatic load_images();
    for (int k = 0; k < H; k++) begin
      h_img[k*W +: W] = W'(mh[k]);
      hist_img[k*W +: W] = W'(mhist[k]);
    end
    for (int k = 0; k < N; k++) begin
      x_img[k*W +: W] = W'(mx[k]);
      d_img[k*W +: W] = W'(md[k]);
      out_img[k*W +: W] = W'(mout[k]);
    end
    @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic apply_cfg();
    intf.operation = 2'(c_op);
    intf.x_count = 8'(c_xc);
    intf.h_coefs_blocks = 6'(c_blk);
    intf.x_samples_u2 = 1'(c_u2);
    intf.x_fract = 1'(c_fract);
    intf.actual_input_bits = 5'(c_bits);
    intf.y_as_out = 1'(c_yo);
    intf.reset_out_ptr = 1'(c_rptr);
    intf.mi = W'(c_mi);
  endtask

  task automatic set_basic(input int op, input int xc, input int blk);
    c_op = op; c_xc = xc; c_blk = blk;
    c_u2 = 1; c_fract = 1; c_bits = 16; c_yo = 1; c_rptr = 1; c_mi = 0;
  endtask

  // freeze_at >= 1 drops en for 5 cycles at that busy cycle
  task automatic run(input string tag, input int freeze_at);
    int cnt;
    int exp_cyc;
    apply_cfg();
    exp_cyc = (c_xc == 0) ? 1 : c_xc * ((c_op == 1) ? 2 * c_blk + 3 : c_blk + 2);
    if (freeze_at >= 1) exp_cyc += 5;
    @(negedge clk);
    check({tag, " idle_before"}, int'(intf.busy), 0);
    intf.start = 1'b1;
    @(negedge clk);
    intf.start = 1'b0;
    cnt = 0;
    while (intf.busy === 1'b1 && cnt < 4000) begin
      cnt++;
      if (freeze_at >= 1 && cnt == freeze_at) intf.en = 1'b0;
      if (freeze_at >= 1 && cnt == freeze_at + 5) intf.en = 1'b1;
      @(negedge clk);
    end
    intf.en = 1'b1;
    check({tag, " busy_cycles"}, cnt, exp_cyc);
    model_run();
    check_bufs(tag);
  endtask

  initial begin
    int n;
    int keep4;
    intf.en = 1'b1;
    intf.start = 1'b0;
    intf.abort_processing = 1'b0;
    c_mi = 0;
    set_basic(int'(OP_FIR), 0, 1);
    apply_cfg();

    // reset state with random images
    clear_model();
    for (int k = 0; k < H; k++) mh[k] = int'($urandom_range(0, 65535)) - 32768;
    for (int k = 0; k < N; k++) mout[k] = int'($urandom_range(0, 65535)) - 32768;
    load_images();
    check("reset busy", int'(intf.busy), 0);
    check("reset state", int'(intf.state_dbg), int'(ST_IDLE));
    check_bufs("reset");

    // x_count = 0: one busy cycle, no writes
    set_basic(int'(OP_LMS), 0, 2);
    run("xc0", -1);

    // FIR identity
    clear_model();
    mh[0] = 256; mx[0] = 256; mx[1] = 512; mx[2] = -768;
    load_images();
    set_basic(int'(OP_FIR), 3, 1);
    run("fir_id", -1);
    check("fir_id out0", out_at(0), 256);
    check("fir_id out1", out_at(1), 512);
    check("fir_id out2", out_at(2), -768);

    // LMS single step, y then err
    clear_model();
    mx[0] = 256; md[0] = 256;
    load_images();
    set_basic(int'(OP_LMS), 1, 1);
    c_mi = 128;
    run("lms_y", -1);
    check("lms_y out0", out_at(0), 0);
    check("lms_y h0", h_at(0), 128);
    clear_model();
    mx[0] = 256; md[0] = 256;
    load_images();
    c_yo = 0;
    run("lms_err", -1);
    check("lms_err out0", out_at(0), 256);

    // saturation
    clear_model();
    mh[0] = 32767; mx[0] = 32767;
    load_images();
    set_basic(int'(OP_FIR), 1, 1);
    run("sat_pos", -1);
    check("sat_pos out0", out_at(0), 32767);
    clear_model();
    mh[0] = -32768; mx[0] = 32767;
    load_images();
    run("sat_neg", -1);
    check("sat_neg out0", out_at(0), -32768);

    // truncation toward zero
    clear_model();
    mh[0] = 128; mx[0] = -1;
    load_images();
    run("trunc_m1", -1);
    check("trunc_m1 out0", out_at(0), 0);
    clear_model();
    mh[0] = 128; mx[0] = -512;
    load_images();
    run("trunc_m512", -1);
    check("trunc_m512 out0", out_at(0), -256);

    // en held low for 5 cycles mid-run
    clear_model();
    for (int k = 0; k < 8; k++) mh[k] = int'($urandom_range(0, 1023)) - 512;
    for (int k = 0; k < 2; k++) begin
      mx[k] = int'($urandom_range(0, 2047)) - 1024;
      md[k] = int'($urandom_range(0, 2047)) - 1024;
    end
    load_images();
    set_basic(int'(OP_LMS), 2, 2);
    c_mi = 64;
    run("freeze", 3);

    // abort after one ADAPT cycle: first block adapted, nothing written
    clear_model();
    for (int k = 0; k < 8; k++) mh[k] = int'($urandom_range(0, 1023)) - 512;
    for (int k = 0; k < 3; k++) begin
      mx[k] = int'($urandom_range(0, 2047)) - 1024;
      md[k] = int'($urandom_range(0, 2047)) - 1024;
    end
    for (int k = 0; k < N; k++) mout[k] = int'($urandom_range(0, 65535)) - 32768;
    load_images();
    set_basic(int'(OP_LMS), 3, 2);
    c_mi = 100;
    apply_cfg();
    intf.start = 1'b1;
    @(negedge clk);
    intf.start = 1'b0;
    n = 0;
    while (intf.state_dbg !== ST_ADAPT && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort reached_adapt", int'(intf.state_dbg === ST_ADAPT), 1);
    @(negedge clk);
    intf.abort_processing = 1'b1;
    @(negedge clk);
    intf.abort_processing = 1'b0;
    check("abort busy", int'(intf.busy), 0);
    model_front(0);
    model_adapt(M);
    repeat (6) @(negedge clk);
    check("abort busy_later", int'(intf.busy), 0);
    check_bufs("abort");

    // nrst pulse mid-run restores images
    clear_model();
    for (int k = 0; k < 8; k++) mh[k] = int'($urandom_range(0, 1023)) - 512;
    for (int k = 0; k < 3; k++) begin
      mx[k] = int'($urandom_range(0, 2047)) - 1024;
      md[k] = int'($urandom_range(0, 2047)) - 1024;
    end
    for (int k = 0; k < N; k++) mout[k] = int'($urandom_range(0, 65535)) - 32768;
    load_images();
    set_basic(int'(OP_LMS), 3, 2);
    c_mi = 90;
    apply_cfg();
    intf.start = 1'b1;
    @(negedge clk);
    intf.start = 1'b0;
    repeat (12) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("nrst busy", int'(intf.busy), 0);
    check_bufs("nrst");
    @(negedge clk);
    nrst = 1'b1;
    mptr = 0;

    // output pointer continuity and explicit pointer reset
    clear_model();
    for (int k = 0; k < 8; k++) mh[k] = int'($urandom_range(0, 1023)) - 512;
    for (int k = 0; k < 4; k++) begin
      mx[k] = int'($urandom_range(0, 2047)) - 1024;
      md[k] = int'($urandom_range(0, 2047)) - 1024;
    end
    for (int k = 0; k < N; k++) mout[k] = int'($urandom_range(0, 65535)) - 32768;
    keep4 = mout[4];
    load_images();
    set_basic(int'(OP_FIR), 2, 2);
    c_rptr = 0;
    run("ptr_a", -1);
    run("ptr_b", -1);
    c_xc = 1;
    c_rptr = 1;
    run("ptr_c", -1);
    check("ptr out4_untouched", out_at(4), keep4);

    // randomized runs, history carried between runs
    clear_model();
    for (int k = 0; k < H; k++) begin
      mh[k] = int'($urandom_range(0, 4000)) - 2000;
      mhist[k] = int'($urandom_range(0, 4000)) - 2000;
    end
    for (int k = 0; k < N; k++) begin
      mx[k] = int'($urandom_range(0, 65535));
      md[k] = int'($urandom_range(0, 8000)) - 4000;
      mout[k] = int'($urandom_range(0, 65535)) - 32768;
    end
    load_images();
    for (int r = 0; r < 10; r++) begin
      c_op = int'($urandom_range(0, 3));
      c_xc = int'($urandom_range(0, 5));
      c_blk = int'($urandom_range(1, 3));
      c_u2 = int'($urandom_range(0, 1));
      c_fract = int'($urandom_range(0, 1));
      c_bits = int'($urandom_range(1, 16));
      c_yo = int'($urandom_range(0, 1));
      c_rptr = int'($urandom_range(0, 1));
      c_mi = int'($urandom_range(0, 511)) - 256;
      run($sformatf("rnd%0d", r), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nlms_filter_top.md
Name: nlms_filter_top

Overview:
Fixed-point adaptive FIR (LMS) filter engine with internal coefficient, input-history, input/desired-sample and output buffers.
- On start it processes a block of x/d samples, writing y (or error) per sample to the output buffer.
- In LMS mode it adapts the coefficients after every sample.
- Sits under the register/AXI wrapper; buffers are register arrays preloaded at reset from parameter-sized vectors.

Parameters:
- LOG2_H_BUFF_HEIGHT, 7, log2 of coefficient buffer depth H.
- LOG2_X_D_BUFF_HEIGHT, 7, log2 of x/d/out buffer depth N.
- SAMPLE_WIDTH, 16, two's-complement sample/coef width W.
- LOG2_NUM_MULS, 2, log2 of parallel multipliers M.
- SAMPLE_Q_FORMAT, 8, fractional bits Q.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  clock enable; when low all state holds.
- start  in  1  one-cycle pulse, accepted only in IDLE.
- abort_processing  in  1  forces IDLE.
- operation  in  2  0=FIR, 1=LMS, 2/3 treated as FIR.
- x_count  in  LOG2_X_D_BUFF_HEIGHT+1  samples to process (0 = none).
- h_coefs_blocks  in  LOG2_H_BUFF_HEIGHT-LOG2_NUM_MULS+1  taps = blocks*M.
- x_samples_u2  in  1  1=x is two's complement, 0=offset-binary.
- x_fract  in  1  1=x already Q-format, 0=integer.
- actual_input_bits  in  5  valid LSBs of x (1..W).
- y_as_out  in  1  1=store y, 0=store err.
- reset_out_ptr  in  1  sampled at start: 1=output pointer to 0.
- mi  in  W  step size, Q-format.
- h_buff_reset_val  in  H*W  coefficient reset image.
- x_fifo_buff_reset_val  in  H*W  history reset image.
- x_buff_ping_reset_val  in  N*W  x reset image.
- d_buff_ping_reset_val  in  N*W  d reset image.
- out_buff_reset_val  in  N*W  output reset image.
- busy  out  1  processing.
- h_buff  out  H*W  current coefficients.
- out_buff  out  N*W  current output buffer.

Behaviour:
- Reset (nrst=0, async): all buffers load their reset images; FSM IDLE, busy=0, output pointer 0, sample index 0.
  - Reset mid-run aborts the run and reloads all buffers.
- FSM states: IDLE, LOAD, FIR, ERR, ADAPT, WRITE.
  - IDLE: start → LOAD. busy rises the cycle after start and is high in every non-IDLE state.
  - LOAD (1 cycle): condition x[i]; shift into history, newest at tap 0, discarding the oldest.
  - FIR (blocks cycles): M products per cycle; y accumulates.
  - ERR (1 cycle): err = d[i] - y (W-bit wrap); adapt = sat((err*mi)/2^Q).
    - Taken only when operation=1; otherwise go directly to WRITE.
  - ADAPT (blocks cycles): h[j] += sat((hist[j]*adapt)/2^Q), W-bit wrap, M taps per cycle. Adaptation uses the same history as the FIR stage.
  - WRITE (1 cycle): out[ptr] = y_as_out ? y : err; ptr increments modulo N; i++.
    - If i == x_count → IDLE, else → LOAD.
  - x_count=0: one-cycle busy pulse, no writes.
- Cycles per sample: FIR = blocks+2; LMS = 2*blocks+3.
- FIR tap term: sat((hist[j]*h[j])/2^Q). Terms are summed into y with W-bit wraparound.
- Arithmetic rules:
  - Products are full 2W-bit signed.
  - /2^Q truncates toward zero.
  - sat clamps to [-2^(W-1), 2^(W-1)-1].
- x conditioning:
  - Take actual_input_bits LSBs; sign-extend if u2, else subtract 2^(bits-1).
  - If x_fract=0, shift left by Q with saturation.
- History persists across runs; d is used unconverted.
- abort_processing: next enabled edge → IDLE, busy=0; a partially adapted h is kept.
- start while busy is ignored.

Decomposition:
- Package nlms_pkg: FSM state enum, operation encodings, sat and truncating-divide functions.
- Sub-module nlms_mac_lane (one multiply + scale + saturate), instantiated M times and shared by the FIR and ADAPT stages.

Test Plan:
- FIR identity: h[0]=256, other taps 0, blocks=1, x=[256,512,-768], x_count=3, y_as_out=1 → out[0..2]=256,512,-768; busy low after 9 cycles.
- LMS single step:
  - Setup: h=0, mi=128, x[0]=256, d[0]=256, operation=1, blocks=1.
  - Expected: out[0]=0, h[0]=128.
  - With y_as_out=0: out[0]=256.
- Saturation: x[0]=32767, h[0]=32767 → tap term 32767; h[0]=-32768 with x=32767 → -32768.
- Rounding: x=-1, h=128 → tap term 0, not -1; x=-512, h=128 → -256.
- Control:
  - abort asserted in ADAPT → busy=0 next cycle, no further out writes.
  - nrst pulse mid-run → h_buff/out_buff equal their reset images.
  - en=0 for 5 cycles → state frozen, run completes 5 cycles later.
- Pointer: two runs of 2 samples with reset_out_ptr=0 → outputs at out[0..3]; third run with reset_out_ptr=1 overwrites out[0].
